// File: rtl/ahb_pkg.sv
// AHB bus encodings shared by the arbiter, plus a helper mapping hburst to beats-1.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  // Undefined-length and single transfers have no remaining beats to count.
  function automatic logic [3:0] burst_beats_m1(input logic [2:0] hburst);
    logic [3:0] r;
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  r = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  r = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: r = 4'd15;
      default:                      r = 4'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at N-1.
module ahb_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] index,
  output logic          any_req
);

  // Scan from the farthest position back to ptr so the closest requester wins.
  always_comb begin
    int j;
    index = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) index = PW'(j);
    end
  end

  assign any_req = |req;
  assign grant   = any_req ? (N'(1) << index) : '0;

endmodule

// File: rtl/ahb_rr_arbiter.sv
// AHB round-robin bus arbiter with burst-aware arbitration points.
// Optional bus locking is compiled in with `define AHB_ARB_LOCK_EN.
module ahb_rr_arbiter
  import ahb_pkg::*;
#(
  parameter int NMST    = 4,
  parameter int DEF_MST = 0,
  localparam int MW     = $clog2(NMST)
) (
  input  logic            hclk,
  input  logic            hresetn,
  input  logic [NMST-1:0] hbusreq,
  input  logic [NMST-1:0] hlock,
  input  logic [1:0]      htrans,
  input  logic [2:0]      hburst,
  input  logic            hready,
  input  logic [1:0]      hresp,
  output logic [NMST-1:0] hgrant,
  output logic [MW-1:0]   hmaster,
  output logic            hmastlock
);

  localparam logic [NMST-1:0] DEF_GNT = NMST'(1) << DEF_MST;
  localparam logic [MW-1:0]   DEF_IDX = MW'(DEF_MST);

  logic [NMST-1:0] grant_q, grant_d;
  logic [MW-1:0]   gidx_q, gidx_d;
  logic [MW-1:0]   ptr_q, ptr_d;
  logic [MW-1:0]   hmaster_q, hmaster_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            retry_q, retry_d;

  logic [NMST-1:0] pick_gnt;
  logic [MW-1:0]   pick_idx;
  logic            pick_any;
  logic            last_beat, open_pt, hold;

  ahb_rr_pick #(.N(NMST), .PW(MW)) u_pick (
    .req     (hbusreq),
    .ptr     (ptr_q),
    .grant   (pick_gnt),
    .index   (pick_idx),
    .any_req (pick_any)
  );

  assign last_beat = (htrans == HTRANS_SEQ) && (cnt_q == 4'd1);
  assign open_pt   = retry_q || last_beat ||
                     ((cnt_q == 4'd0) &&
                      (htrans == HTRANS_IDLE || htrans == HTRANS_BUSY ||
                       hburst == HBURST_SINGLE || hburst == HBURST_INCR));

`ifdef AHB_ARB_LOCK_EN
  logic lock_q, lock_d;
  logic hmastlock_q, hmastlock_d;
`else
  logic unused_lock;
  assign unused_lock = ^hlock;
`endif

  always_comb begin
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    hmaster_d = hmaster_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    hold      = 1'b0;
`ifdef AHB_ARB_LOCK_EN
    lock_d      = lock_q;
    hmastlock_d = hmastlock_q;
`endif
    if (!hready) begin
      // First cycle of a two-cycle RETRY/SPLIT: remember it, act on the next ready edge.
      if (hresp == HRESP_RETRY || hresp == HRESP_SPLIT) retry_d = 1'b1;
    end else begin
      retry_d   = 1'b0;
      hmaster_d = gidx_q;
`ifdef AHB_ARB_LOCK_EN
      hmastlock_d = hlock[gidx_q];
`endif
      if (retry_q) begin
        cnt_d = 4'd0;
      end else begin
        case (htrans)
          HTRANS_NONSEQ: cnt_d = burst_beats_m1(hburst);
          HTRANS_SEQ:    cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
          HTRANS_IDLE:   cnt_d = 4'd0;
          default:       cnt_d = cnt_q;
        endcase
      end
      if (open_pt) begin
`ifdef AHB_ARB_LOCK_EN
        // A locked owner keeps the bus, and for one more point after it releases hlock.
        if (hlock[gidx_q]) begin
          hold   = 1'b1;
          lock_d = 1'b1;
        end else if (lock_q) begin
          hold   = 1'b1;
          lock_d = 1'b0;
        end
`endif
        if (!hold) begin
          if (pick_any) begin
            grant_d = pick_gnt;
            gidx_d  = pick_idx;
            ptr_d   = (pick_idx == MW'(NMST - 1)) ? '0 : pick_idx + MW'(1);
          end else begin
            grant_d = DEF_GNT;
            gidx_d  = DEF_IDX;
          end
        end
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      grant_q   <= DEF_GNT;
      gidx_q    <= DEF_IDX;
      ptr_q     <= '0;
      hmaster_q <= DEF_IDX;
      cnt_q     <= 4'd0;
      retry_q   <= 1'b0;
    end else begin
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      ptr_q     <= ptr_d;
      hmaster_q <= hmaster_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
    end
  end

`ifdef AHB_ARB_LOCK_EN
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      lock_q      <= 1'b0;
      hmastlock_q <= 1'b0;
    end else begin
      lock_q      <= lock_d;
      hmastlock_q <= hmastlock_d;
    end
  end
  assign hmastlock = hmastlock_q;
`else
  assign hmastlock = 1'b0;
`endif

  assign hgrant  = grant_q;
  assign hmaster = hmaster_q;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed testbench for ahb_rr_arbiter (NMST=4, DEF_MST=0) with hand-computed expectations.
module tb_ahb_rr_arbiter;

  localparam logic [1:0] IDLE = 2'b00, NSQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SG = 3'b000, INCR4 = 3'b011, WRAP8 = 3'b100, INCR16 = 3'b111;
  localparam logic [1:0] OK = 2'b00, RETRY = 2'b10;

  logic       hclk = 1'b0;
  logic       hresetn;
  logic [3:0] hbusreq, hlock, hgrant;
  logic [1:0] htrans, hresp, hmaster;
  logic [2:0] hburst;
  logic       hready, hmastlock;

  int n_vec = 0;
  int n_err = 0;

  always #5 hclk = ~hclk;

  ahb_rr_arbiter #(.NMST(4), .DEF_MST(0)) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hresp     (hresp),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmastlock (hmastlock)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] req, input logic [1:0] tr, input logic [2:0] bu,
                      input logic rdy, input logic [1:0] rsp);
    hbusreq = req;
    htrans  = tr;
    hburst  = bu;
    hready  = rdy;
    hresp   = rsp;
    @(posedge hclk);
    #1;
  endtask

  task automatic do_reset();
    hresetn = 1'b0;
    hbusreq = '0;
    hlock   = '0;
    htrans  = IDLE;
    hburst  = SG;
    hready  = 1'b1;
    hresp   = OK;
    repeat (2) @(posedge hclk);
    #1;
    hresetn = 1'b1;
  endtask

  logic [3:0] rr_exp [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};

  initial begin
    // Reset state and plain round-robin over single transfers.
    do_reset();
    check("rst_gnt", hgrant, 4'b0001);
    check("rst_mst", hmaster, 2'd0);
    check("rst_lock", hmastlock, 1'b0);
    step(4'b1111, IDLE, SG, 1'b1, OK);
    check("rr_0", hgrant, rr_exp[0]);
    for (int i = 1; i < 7; i++) begin
      step(4'b1111, NSQ, SG, 1'b1, OK);
      check($sformatf("rr_%0d", i), hgrant, rr_exp[i]);
    end
    check("rr_mst", hmaster, 2'd1);
    step(4'b0000, IDLE, SG, 1'b1, OK);
    check("rr_def", hgrant, 4'b0001);
    step(4'b1111, IDLE, SG, 1'b1, OK);
    check("rr_ptr_keep", hgrant, 4'b1000);

    // INCR4 on master 2: it drops hbusreq, master 1 requests, stall at beat 3.
    do_reset();
    step(4'b0100, IDLE, SG, 1'b1, OK);
    check("b_gnt", hgrant, 4'b0100);
    step(4'b0100, NSQ, INCR4, 1'b1, OK);
    check("b_beat1", hgrant, 4'b0100);
    check("b_mst", hmaster, 2'd2);
    step(4'b0010, SEQ, INCR4, 1'b1, OK);
    check("b_drop", hgrant, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      step(4'b0010, SEQ, INCR4, 1'b0, OK);
      check($sformatf("b_stall%0d", i), hgrant, 4'b0100);
    end
    check("b_stall_mst", hmaster, 2'd2);
    step(4'b0010, SEQ, INCR4, 1'b1, OK);
    check("b_beat3", hgrant, 4'b0100);
    step(4'b0010, SEQ, INCR4, 1'b1, OK);
    check("b_hand", hgrant, 4'b0010);
    check("b_mst_hold", hmaster, 2'd2);
    step(4'b0010, NSQ, SG, 1'b1, OK);
    check("b_mst1", hmaster, 2'd1);

    // WRAP8 on master 3 retried at beat 2.
    do_reset();
    step(4'b1000, IDLE, SG, 1'b1, OK);
    check("c_gnt", hgrant, 4'b1000);
    step(4'b1000, NSQ, WRAP8, 1'b1, OK);
    step(4'b1001, SEQ, WRAP8, 1'b1, OK);
    check("c_beat2", hgrant, 4'b1000);
    step(4'b1001, SEQ, WRAP8, 1'b0, RETRY);
    check("c_retry1", hgrant, 4'b1000);
    step(4'b1001, IDLE, WRAP8, 1'b1, RETRY);
    check("c_regrant", hgrant, 4'b0001);
    check("c_mst", hmaster, 2'd3);

    // Reset mid INCR16 at beat 7.
    do_reset();
    step(4'b0100, IDLE, SG, 1'b1, OK);
    step(4'b0100, NSQ, INCR16, 1'b1, OK);
    repeat (6) step(4'b0100, SEQ, INCR16, 1'b1, OK);
    check("e_pre_gnt", hgrant, 4'b0100);
    check("e_pre_mst", hmaster, 2'd2);
    #2 hresetn = 1'b0;
    #1;
    check("e_rst_gnt", hgrant, 4'b0001);
    check("e_rst_mst", hmaster, 2'd0);
    check("e_rst_lock", hmastlock, 1'b0);
    @(posedge hclk);
    #1 hresetn = 1'b1;
    step(4'b0100, IDLE, SG, 1'b0, OK);
    check("e_frz", hgrant, 4'b0001);
    step(4'b0100, IDLE, SG, 1'b1, OK);
    check("e_first", hgrant, 4'b0100);

`ifdef AHB_ARB_LOCK_EN
    // Master 1 holds the bus for two locked INCR4 bursts.
    do_reset();
    step(4'b0010, IDLE, SG, 1'b1, OK);
    check("l_gnt", hgrant, 4'b0010);
    hlock = 4'b0010;
    for (int b = 0; b < 2; b++) begin
      step(4'b1111, NSQ, INCR4, 1'b1, OK);
      check($sformatf("l_mlock%0d", b), hmastlock, 1'b1);
      repeat (3) step(4'b1111, SEQ, INCR4, 1'b1, OK);
      check($sformatf("l_hold%0d", b), hgrant, 4'b0010);
    end
    hlock = 4'b0000;
    step(4'b1111, IDLE, SG, 1'b1, OK);
    check("l_extra", hgrant, 4'b0010);
    step(4'b1111, IDLE, SG, 1'b1, OK);
    check("l_pass", hgrant, 4'b0100);
    check("l_unlock", hmastlock, 1'b0);
`else
    // hlock has no effect when locking is not built in.
    do_reset();
    hlock = 4'b0010;
    step(4'b0010, IDLE, SG, 1'b1, OK);
    check("n_gnt", hgrant, 4'b0010);
    step(4'b1111, NSQ, SG, 1'b1, OK);
    check("n_pass", hgrant, 4'b0100);
    check("n_mlock", hmastlock, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
